// File: rtl/param_proc_pkg.sv
// Shared opcode, state and bus-select encodings for param_proc.
// Latency: none (types only). Backpressure: not applicable.
// Optional feature macro used by the design: PARAM_PROC_MVNZ_EN.
package param_proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // R0-R7 occupy codes 0-7 so a register index maps straight onto a select.
    typedef enum logic [3:0] {
        SEL_R0   = 4'd0,
        SEL_R1   = 4'd1,
        SEL_R2   = 4'd2,
        SEL_R3   = 4'd3,
        SEL_R4   = 4'd4,
        SEL_R5   = 4'd5,
        SEL_R6   = 4'd6,
        SEL_R7   = 4'd7,
        SEL_G    = 4'd8,
        SEL_DIN  = 4'd9,
        SEL_NONE = 4'd10
    } bus_sel_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/param_proc_alu.sv
// W-wide ALU for add, sub, and, xor; other opcodes yield zero.
// Latency: combinational. Backpressure: none.
module param_proc_alu
    import param_proc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a + ~b + W'(1);
            OP_AND:  result = a & b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/param_proc.sv
// Multi-cycle W-bit processor: R0-R7, A, G on one shared bus; PARAM_PROC_MVNZ_EN enables mvnz.
// Latency: mv/mvi/nop 1 cycle after the Run edge, ALU ops 3 cycles; Done marks the last step.
// Backpressure: Run is sampled only in T0, one idle T0 cycle separates instructions.
module param_proc
    import param_proc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [W-1:0] DIN,
    input  logic         Run,
    output logic         Done,
    output logic [W-1:0] BusWires
);

    state_t       state;
    logic [8:0]   ir;
    logic [W-1:0] r_q [8];
    logic [W-1:0] a_q;
    logic [W-1:0] g_q;
    logic [W-1:0] alu_result;

    logic [2:0]   op;
    logic [2:0]   rx;
    logic [2:0]   ry;
    bus_sel_t     bus_sel;
    logic         rx_wr;
    logic         a_wr;
    logic         g_wr;
    logic         done_c;

    assign op = ir[8:6];
    assign rx = ir[5:3];
    assign ry = ir[2:0];

    param_proc_alu #(.W(W)) u_alu (
        .a      (a_q),
        .b      (BusWires),
        .op     (op),
        .result (alu_result)
    );

    always_comb begin
        bus_sel = SEL_NONE;
        rx_wr   = 1'b0;
        a_wr    = 1'b0;
        g_wr    = 1'b0;
        done_c  = 1'b0;
        case (state)
            T1: begin
                case (op)
                    OP_MV: begin
                        bus_sel = bus_sel_t'({1'b0, ry});
                        rx_wr   = 1'b1;
                        done_c  = 1'b1;
                    end
                    OP_MVI: begin
                        bus_sel = SEL_DIN;
                        rx_wr   = 1'b1;
                        done_c  = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                        bus_sel = bus_sel_t'({1'b0, rx});
                        a_wr    = 1'b1;
                    end
`ifdef PARAM_PROC_MVNZ_EN
                    OP_MVNZ: begin
                        done_c = 1'b1;
                        if (g_q != '0) begin
                            bus_sel = bus_sel_t'({1'b0, ry});
                            rx_wr   = 1'b1;
                        end
                    end
`endif
                    default: done_c = 1'b1;
                endcase
            end
            T2: begin
                bus_sel = bus_sel_t'({1'b0, ry});
                g_wr    = 1'b1;
            end
            T3: begin
                bus_sel = SEL_G;
                rx_wr   = 1'b1;
                done_c  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        BusWires = '0;
        case (bus_sel)
            SEL_R0, SEL_R1, SEL_R2, SEL_R3,
            SEL_R4, SEL_R5, SEL_R6, SEL_R7: BusWires = r_q[bus_sel[2:0]];
            SEL_G:                          BusWires = g_q;
            SEL_DIN:                        BusWires = DIN;
            default:                        BusWires = '0;
        endcase
    end

    assign Done = done_c;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= T0;
            ir    <= '0;
            a_q   <= '0;
            g_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            case (state)
                T0: if (Run) begin
                    ir    <= DIN[8:0];
                    state <= T1;
                end
                T1:      state <= is_alu_op(op) ? T2 : T0;
                T2:      state <= T3;
                default: state <= T0;
            endcase
            if (rx_wr) r_q[rx] <= BusWires;
            if (a_wr)  a_q     <= BusWires;
            if (g_wr)  g_q     <= alu_result;
        end
    end

endmodule

// File: doc/param_proc.md
Name: param_proc

Overview:
- Parametrised multi-cycle processor, successor to the 9-bit proc.
- Adds data-width parameter W, three new opcodes (and, xor, optional mvnz) and a defined idle bus value.
- Keeps eight general registers R0-R7, accumulator A and result register G, all on one shared bus (BusWires).
- Sits beside a memory/switch source that drives DIN.

Parameters:
- W, 16, datapath width in bits (registers, bus, ALU); W >= 9 required.

Ports:
- Clock  input  1  system clock, rising-edge.
- Resetn  input  1  asynchronous active-low reset.
- DIN  input  W  instruction (DIN[8:0], upper bits ignored) or mvi immediate (full W bits).
- Run  input  1  start request; sampled only in T0.
- Done  output  1  high during the final step of an instruction.
- BusWires  output  W  shared bus value.

Behaviour:
- Instruction format is DIN[8:6]=III, [5:3]=XXX (Rx), [2:0]=YYY (Ry).
- Opcodes:
  - 000 mv Rx,Ry
  - 001 mvi Rx,#D
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 100 and Rx,Ry
  - 101 mvnz Rx,Ry (optional)
  - 110 xor Rx,Ry
  - 111 reserved NOP
- FSM states are T0, T1, T2, T3; state register and IR update on the rising Clock edge.
- T0:
  - If Run=1, IR <= DIN[8:0] and go to T1; otherwise stay in T0.
  - Done=0.
- T1:
  - mv: bus=Ry, Rx<=bus, Done=1, then T0.
  - mvi: bus=DIN (the immediate is presented the cycle after the instruction), Rx<=bus, Done=1, then T0.
  - add/sub/and/xor: bus=Rx, A<=bus, then T2.
  - mvnz: see Optional Feature.
  - 111: Done=1, no writes, then T0.
- T2 (ALU ops): bus=Ry, G <= A op bus, then T3.
- T3: bus=G, Rx<=bus, Done=1, then T0.
- Latency, counted from the Run-sampling edge to the final Done cycle: mv/mvi/NOP take 1 cycle (T1); ALU ops take 3 cycles (T1-T3).
- Run is ignored in T1-T3. With Run held high, a new instruction is fetched in the T0 following Done, so there is one idle cycle between instructions.
- Arithmetic:
  - add/sub are modulo 2^W; no carry or overflow is stored.
  - sub computes A - Ry as A + ~Ry + 1.
- Rx==Ry is legal:
  - add R0,R0 doubles R0.
  - sub R0,R0 gives 0.
- Bus drives all-zero whenever no source is selected (T0, NOP); exactly one source is driven otherwise.
- G keeps its value between instructions; only T2 of an ALU op writes G.
- Reset (asynchronous, any state):
  - FSM goes to T0.
  - IR, A, G and R0-R7 become 0.
  - Done=0, BusWires=0.
  - An interrupted instruction is abandoned with no partial write after Resetn rises.
- Done is combinational from state and IR and is never high in T0.

Optional Feature:
- Macro PARAM_PROC_MVNZ_EN.
- Defined: opcode 101 mvnz Rx,Ry in T1.
  - If G != 0: bus=Ry, Rx<=bus.
  - Else: bus=0, no write.
  - Done=1 in either case, then T0.
- Undefined: opcode 101 behaves exactly as 111 (NOP, Done in T1, no writes).

Decomposition:
- Package param_proc_pkg holds:
  - opcode localparams OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_MVNZ, OP_XOR, OP_NOP (3 bits);
  - state encoding T0..T3 (2 bits);
  - bus-select encoding (R0-R7, G, DIN, NONE).
- One sub-module, param_proc_alu: combinational, W-wide, inputs A, B, op; output result. Handles add, sub, and, xor.
- Registers are inline in param_proc.

Test Plan (W=16):
- Reset, then Run with mvi R0 (0x040), next cycle DIN=0x0005; then mv R1,R0 (0x008) -> R0=0x0005, then R1=0x0005; Done for exactly 1 cycle each, in T1.
- add R0,R1 (0x081) with R0=R1=5 -> BusWires shows 5 in T1 and T2; G=0x000A; R0=0x000A at the end of T3; Done only in T3.
- mvi R2,#1 then mvi R3,#7, then sub R2,R3 -> R2=0xFFFA (wrap-around). Then and R2,R3 -> R2=0x0002. Then xor R2,R3 -> R2=0x0005.
- With macro defined: sub R0,R0 (G=0), then mvnz R5,R3 -> R5 unchanged. Then add R3,R3 (G=14), then mvnz R5,R3 -> R5=0x000E. Without macro: both mvnz leave R5 unchanged and Done is still pulsed in T1.
- Resetn low for one cycle during T2 of add R4,R3 -> all registers 0, state T0, Done=0, BusWires=0; no write of R4 after release.
- Run held low for 5 cycles -> FSM stays in T0, BusWires=0. Run held high across two back-to-back mv -> each completes, with a T0 cycle between them.
